// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and helpers for the spike-rate decoder: FSM state encoding
// and the saturating counter increment.
package spike_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INTEGRATE = 2'd1,
        ST_ARGMAX    = 2'd2,
        ST_REPORT    = 2'd3
    } state_t;

    localparam int unsigned SAT_STEP = 1;

    // Add SAT_STEP unless already at max_value; never wraps.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'(SAT_STEP);
    endfunction

endpackage

// File: rtl/spike_rate_decoder_counter.sv
// Per-class spike counter: synchronous clear, enable, saturates at all-ones.
module spike_counter
    import spike_decoder_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= COUNT_WIDTH'(sat_inc(32'(count), 32'(COUNT_MAX)));
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate-coded classifier readout: counts output-layer spikes over a window,
// then scans the counters for the argmax. Optional overflow flag: SPIKE_DECODER_OVF_EN.
module spike_rate_decoder
    import spike_decoder_pkg::*;
#(
    parameter  int unsigned NUM_CLASSES  = 4,
    parameter  int unsigned COUNT_WIDTH  = 8,
    parameter  int unsigned WINDOW_WIDTH = 16,
    localparam int unsigned IDX_W        = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CLASSES-1:0]  spikes_in,
    input  logic                    start,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [IDX_W-1:0]        winner_idx,
    output logic [COUNT_WIDTH-1:0]  winner_count,
    output logic                    tie
`ifdef SPIKE_DECODER_OVF_EN
    ,
    output logic                    overflow
`endif
);

    state_t                  state;
    state_t                  state_nxt;
    logic [WINDOW_WIDTH-1:0] win_rem;
    logic [IDX_W-1:0]        scan_idx;
    logic                    start_acc;
    logic                    cnt_clear;
    logic                    cnt_en;
    logic [COUNT_WIDTH-1:0]  counts [NUM_CLASSES];
    logic [COUNT_WIDTH-1:0]  scan_count;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (window_len == '0) ? ST_ARGMAX : ST_INTEGRATE;
                end
            end
            ST_INTEGRATE: begin
                if (win_rem == WINDOW_WIDTH'(1)) begin
                    state_nxt = ST_ARGMAX;
                end
            end
            ST_ARGMAX: begin
                if (scan_idx == IDX_W'(NUM_CLASSES - 1)) begin
                    state_nxt = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        busy      = 1'b0;
        start_acc = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        busy      = (state != ST_IDLE);
        start_acc = (state == ST_IDLE) && start;
        cnt_clear = start_acc;
        cnt_en    = (state == ST_INTEGRATE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
            spike_counter #(
                .COUNT_WIDTH(COUNT_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (cnt_clear),
                .enable(cnt_en && spikes_in[gi]),
                .count (counts[gi])
            );
        end
    endgenerate

    assign scan_count = counts[scan_idx];

    // Window countdown and argmax scan pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_rem  <= '0;
            scan_idx <= '0;
        end else begin
            if (start_acc) begin
                win_rem <= window_len;
            end else if (state == ST_INTEGRATE) begin
                win_rem <= win_rem - WINDOW_WIDTH'(1);
            end
            scan_idx <= (state == ST_ARGMAX) ? scan_idx + IDX_W'(1) : '0;
        end
    end

    // Running best; first class seeds it, lowest index keeps a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_idx   <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
        end else if (state == ST_ARGMAX) begin
            if (scan_idx == '0) begin
                winner_idx   <= '0;
                winner_count <= scan_count;
                tie          <= 1'b0;
            end else if (scan_count > winner_count) begin
                winner_idx   <= scan_idx;
                winner_count <= scan_count;
                tie          <= 1'b0;
            end else if (scan_count == winner_count) begin
                tie <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
        end else begin
            result_valid <= (state_nxt == ST_REPORT);
        end
    end

`ifdef SPIKE_DECODER_OVF_EN
    logic [NUM_CLASSES-1:0] sat;

    always_comb begin
        sat = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            sat[i] = (counts[i] == '1);
        end
    end

    // Saturated counters hold until the next start, so sampling at REPORT entry suffices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (state_nxt == ST_REPORT) && (|sat);
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed, table-driven bench for spike_rate_decoder (4 classes, 8-bit counts).
module tb_spike_rate_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  spikes_in;
    logic        start;
    logic [15:0] window_len;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  winner_idx;
    logic [7:0]  winner_count;
    logic        tie;
`ifdef SPIKE_DECODER_OVF_EN
    logic        overflow;
`endif

    spike_rate_decoder #(
        .NUM_CLASSES (4),
        .COUNT_WIDTH (8),
        .WINDOW_WIDTH(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spikes_in   (spikes_in),
        .start       (start),
        .window_len  (window_len),
        .busy        (busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .winner_idx  (winner_idx),
        .winner_count(winner_count),
        .tie         (tie)
`ifdef SPIKE_DECODER_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned win;
        int unsigned n0, n1, n2, n3;
        int unsigned exp_idx;
        int unsigned exp_cnt;
        int unsigned exp_tie;
        int unsigned exp_ovf;
    } vec_t;

    vec_t vecs [8];
    int   n_tests;
    int   n_fail;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Called at a negedge in IDLE: issues start there, drives spikes for the
    // first n_i window cycles of class i and all-ones outside the window.
    task automatic run_window(input int unsigned win, input int unsigned n0, input int unsigned n1,
                              input int unsigned n2, input int unsigned n3, output int lat);
        int unsigned n [4];
        logic [3:0]  s;
        n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
        start      = 1'b1;
        window_len = 16'(win);
        spikes_in  = 4'hF;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            s = 4'hF;
            if ((lat - 1) < int'(win)) begin
                for (int i = 0; i < 4; i++) s[i] = ((lat - 1) < int'(n[i]));
            end
            spikes_in = s;
        end while (!result_valid && lat < 2000);
        spikes_in = 4'h0;
    endtask

    task automatic check_result(input string name, input int lat, input int unsigned exp_lat,
                                input int unsigned idx, input int unsigned cnt,
                                input int unsigned t, input int unsigned ovf);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_valid"}, result_valid, 1);
        chk({name, "_busy"}, busy, 1);
        chk({name, "_idx"}, winner_idx, idx);
        chk({name, "_count"}, winner_count, cnt);
        chk({name, "_tie"}, tie, t);
`ifdef SPIKE_DECODER_OVF_EN
        chk({name, "_overflow"}, overflow, ovf);
`else
        if (ovf > 1) $display("note: bad ovf entry in %s", name);
`endif
    endtask

    // Leaves the bench at the negedge of the IDLE cycle after the handshake
    task automatic handshake(input string name);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk({name, "_valid_drop"}, result_valid, 0);
        chk({name, "_busy_drop"}, busy, 0);
    endtask

    initial begin
        int lat;
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{win: 10,  n0: 0,   n1: 0, n2: 10, n3: 0, exp_idx: 2, exp_cnt: 10,  exp_tie: 0, exp_ovf: 0};
        vecs[1] = '{win: 6,   n0: 0,   n1: 3, n2: 0,  n3: 3, exp_idx: 1, exp_cnt: 3,   exp_tie: 1, exp_ovf: 0};
        vecs[2] = '{win: 0,   n0: 0,   n1: 0, n2: 0,  n3: 0, exp_idx: 0, exp_cnt: 0,   exp_tie: 1, exp_ovf: 0};
        vecs[3] = '{win: 300, n0: 300, n1: 0, n2: 0,  n3: 0, exp_idx: 0, exp_cnt: 255, exp_tie: 0, exp_ovf: 1};
        vecs[4] = '{win: 5,   n0: 2,   n1: 4, n2: 4,  n3: 5, exp_idx: 3, exp_cnt: 5,   exp_tie: 0, exp_ovf: 0};
        vecs[5] = '{win: 3,   n0: 3,   n1: 1, n2: 3,  n3: 0, exp_idx: 0, exp_cnt: 3,   exp_tie: 1, exp_ovf: 0};
        vecs[6] = '{win: 1,   n0: 0,   n1: 0, n2: 0,  n3: 1, exp_idx: 3, exp_cnt: 1,   exp_tie: 0, exp_ovf: 0};
        vecs[7] = '{win: 8,   n0: 1,   n1: 7, n2: 2,  n3: 7, exp_idx: 1, exp_cnt: 7,   exp_tie: 1, exp_ovf: 0};

        rst_n        = 1'b0;
        spikes_in    = 4'h0;
        start        = 1'b0;
        window_len   = 16'd0;
        result_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_idx", winner_idx, 0);
        chk("reset_count", winner_count, 0);
        chk("reset_tie", tie, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_window(vecs[v].win, vecs[v].n0, vecs[v].n1, vecs[v].n2, vecs[v].n3, lat);
            check_result($sformatf("vec%0d", v), lat, vecs[v].win + 5, vecs[v].exp_idx,
                         vecs[v].exp_cnt, vecs[v].exp_tie, vecs[v].exp_ovf);
            handshake($sformatf("vec%0d", v));
        end

        // Backpressure: result held, start pulses ignored
        run_window(7, 0, 6, 2, 6, lat);
        check_result("hold", lat, 12, 1, 6, 1, 0);
        for (int c = 0; c < 20; c++) begin
            start      = c[0];
            window_len = 16'(c + 1);
            spikes_in  = 4'hF;
            @(negedge clk);
            chk($sformatf("hold_valid_c%0d", c), result_valid, 1);
            chk($sformatf("hold_word_c%0d", c), {winner_idx, winner_count, tie}, {2'd1, 8'd6, 1'b1});
        end
        start     = 1'b0;
        spikes_in = 4'h0;
        handshake("hold");
        run_window(2, 0, 2, 1, 0, lat);
        check_result("after_hold", lat, 7, 1, 2, 0, 0);
        handshake("after_hold");

        // Asynchronous reset in the middle of a window
        start      = 1'b1;
        window_len = 16'd50;
        spikes_in  = 4'b1010;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrun_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", result_valid, 0);
        chk("async_rst_word", {winner_idx, winner_count, tie}, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        spikes_in = 4'h0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        run_window(4, 1, 0, 4, 2, lat);
        check_result("post_rst", lat, 9, 2, 4, 0, 0);
        handshake("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
